arb_mux: RTL and testbench



---
 rtl/arb_mux.sv | 102 ++++++++++
 tb/tb_arb_mux.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// arb_mux: merges CHANNELS valid/ready input streams onto one
// registered output stream, fixed-priority (MODE 0) or round-robin (MODE 1).
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-high
//   i_data   packed input data, channel k at [k*WIDTH +: WIDTH]
//   i_valid  per-channel valid
//   o_ready  per-channel ready, one-hot or zero
//   o_data   registered output data
//   o_valid  output register holds a beat
//   o_sel    channel that supplied o_data
//   i_ready  downstream ready
module arb_mux #(
   parameter int WIDTH     = 16,
   parameter int CHANNELS  = 4,
   parameter int MODE      = 1,
   parameter int SEL_WIDTH = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] i_data,
   input  logic [CHANNELS-1:0]       i_valid,
   output logic [CHANNELS-1:0]       o_ready,
   output logic [WIDTH-1:0]          o_data,
   output logic                      o_valid,
   output logic [SEL_WIDTH-1:0]      o_sel,
   input  logic                      i_ready
);

   localparam logic [SEL_WIDTH:0] NCH = (SEL_WIDTH+1)'(CHANNELS);

   logic                 load_en;
   logic                 any_valid;
   logic                 accept;
   logic                 found;
   logic [SEL_WIDTH-1:0] rr_ptr;
   logic [SEL_WIDTH-1:0] base;
   logic [SEL_WIDTH-1:0] idx;
   logic [SEL_WIDTH:0]   sum;
   logic [SEL_WIDTH-1:0] grant;
   logic [SEL_WIDTH-1:0] nxt_ptr;
   logic [WIDTH-1:0]     sel_data;

   // Output register is empty or being drained this cycle.
   assign load_en   = !o_valid || i_ready;
   assign any_valid = |i_valid;
   assign accept    = load_en && any_valid;

   // Search starts at base and wraps; base is pinned to 0 in
   // fixed-priority mode so the lowest valid index wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      base  = (MODE == 1) ? rr_ptr : '0;
      for (int i = 0; i < CHANNELS; i++) begin
         sum = {1'b0, base} + (SEL_WIDTH+1)'(i);
         if (sum >= NCH)
            sum = sum - NCH;
         idx = sum[SEL_WIDTH-1:0];
         if (!found && i_valid[idx]) begin
            found = 1'b1;
            grant = idx;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (grant == SEL_WIDTH'(k))
            sel_data = i_data[k*WIDTH +: WIDTH];
      end
   end

   assign nxt_ptr = (grant == SEL_WIDTH'(CHANNELS-1)) ?
                    '0 : grant + SEL_WIDTH'(1);

   assign o_ready = accept ?
                    (CHANNELS'(1) << grant) : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_sel   <= '0;
         rr_ptr  <= '0;
      end else if (accept) begin
         o_valid <= 1'b1;
         o_data  <= sel_data;
         o_sel   <= grant;
         if (MODE == 1)
            rr_ptr <= nxt_ptr;
      end else if (i_ready) begin
         // Drained with nothing new: data/sel keep last values.
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed checks of arb_mux in fixed-priority, round-robin
// and 2-channel 1-bit configurations against a behavioural model.
module tb_arb_mux;

   logic clk;
   logic reset;

   // Instance 0: MODE 0, instance 1: MODE 1 (both 4 x 16 bit).
   logic [63:0] xd [2];
   logic [3:0]  xv [2];
   logic        xr [2];
   logic [3:0]  yr [2];
   logic [15:0] yd [2];
   logic        yv [2];
   logic [1:0]  ys [2];

   // Instance 2: CHANNELS=2, WIDTH=1, MODE 0.
   logic [1:0] c_data;
   logic [1:0] c_valid;
   logic [1:0] c_ready;
   logic       c_odata;
   logic       c_ovalid;
   logic [0:0] c_osel;
   logic       c_iready;

   int n_cmp;
   int n_bad;
   bit run_c;

   // Model state.
   logic        mv [2];
   logic [15:0] md [2];
   logic [1:0]  ms [2];
   int          mp [2];
   logic [1:0]  sbq[$];

   arb_mux #(.WIDTH(16), .CHANNELS(4), .MODE(0)) u_a (
      .clk(clk), .reset(reset),
      .i_data(xd[0]), .i_valid(xv[0]), .o_ready(yr[0]),
      .o_data(yd[0]), .o_valid(yv[0]), .o_sel(ys[0]),
      .i_ready(xr[0]));

   arb_mux #(.WIDTH(16), .CHANNELS(4), .MODE(1)) u_b (
      .clk(clk), .reset(reset),
      .i_data(xd[1]), .i_valid(xv[1]), .o_ready(yr[1]),
      .o_data(yd[1]), .o_valid(yv[1]), .o_sel(ys[1]),
      .i_ready(xr[1]));

   arb_mux #(.WIDTH(1), .CHANNELS(2), .MODE(0)) u_c (
      .clk(clk), .reset(reset),
      .i_data(c_data), .i_valid(c_valid), .o_ready(c_ready),
      .o_data(c_odata), .o_valid(c_ovalid), .o_sel(c_osel),
      .i_ready(c_iready));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int inst,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d] got %h want %h", nm, inst, act, exp);
      end
   endtask

   // First valid channel searching from base with wrap; -1 if none.
   function automatic int pick(input logic [3:0] v, input int base);
      for (int i = 0; i < 4; i++) begin
         if (v[(base + i) % 4])
            return (base + i) % 4;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_ready(input int i);
      int g;
      g = pick(xv[i], mp[i]);
      if ((!mv[i] || xr[i]) && g >= 0)
         return 4'(1 << g);
      return 4'b0000;
   endfunction

   // Behavioural model: a slot that is filled from the winning
   // channel whenever it is empty or being drained.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            mv[i] <= 1'b0;
            md[i] <= '0;
            ms[i] <= '0;
            mp[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            int g;
            g = pick(xv[i], mp[i]);
            if ((!mv[i] || xr[i]) && g >= 0) begin
               mv[i] <= 1'b1;
               md[i] <= xd[i][g*16 +: 16];
               ms[i] <= 2'(g);
               if (i == 1)
                  mp[i] <= (g + 1) % 4;
            end else if (mv[i] && xr[i]) begin
               mv[i] <= 1'b0;
            end
         end
      end
   end

   // Per-cycle compare of both 4-channel instances.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk("o_valid", i, 32'(yv[i]), 32'(mv[i]));
         chk("o_data", i, 32'(yd[i]), 32'(md[i]));
         chk("o_sel", i, 32'(ys[i]), 32'(ms[i]));
         chk("o_ready", i, 32'(yr[i]), 32'(exp_ready(i)));
      end
   end

   // Scoreboard for the 2-channel instance.
   always @(negedge clk) begin
      if (run_c && !reset) begin
         logic [1:0] er;
         logic [1:0] acc;
         er = 2'b00;
         if ((!c_ovalid || c_iready) && c_valid != 2'b00)
            er = c_valid[0] ? 2'b01 : 2'b10;
         chk("c_ready", 2, 32'(c_ready), 32'(er));
         chk("c_pending", 2, 32'(c_ovalid),
             32'(sbq.size() != 0));
         if (c_ovalid && c_iready && sbq.size() != 0)
            chk("c_beat", 2, 32'({c_osel, c_odata}),
                32'(sbq.pop_front()));
         acc = c_valid & c_ready;
         if (acc[0])
            sbq.push_back({1'b0, c_data[0]});
         else if (acc[1])
            sbq.push_back({1'b1, c_data[1]});
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      run_c = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         xd[i] = '0;
         xv[i] = '0;
         xr[i] = 1'b0;
      end
      c_data = '0;
      c_valid = '0;
      c_iready = 1'b0;
      repeat (2) step();
      reset = 1'b0;

      // Reset state.
      @(negedge clk);
      chk("rst_valid", 0, 32'(yv[0]), 32'h0);
      chk("rst_data", 0, 32'(yd[0]), 32'h0);
      chk("rst_sel", 0, 32'(ys[0]), 32'h0);
      chk("rst_ready", 0, 32'(yr[0]), 32'h0);
      chk("rst_ready", 1, 32'(yr[1]), 32'h0);

      // Fixed priority: ch1 beats ch3 until ch1 drops.
      step();
      xd[0] = {16'h3333, 16'h0000, 16'h1111, 16'h0000};
      xv[0] = 4'b1010;
      xr[0] = 1'b1;
      @(negedge clk);
      chk("fp_ready0", 0, 32'(yr[0]), 32'h2);
      step();
      @(negedge clk);
      chk("fp_valid", 0, 32'(yv[0]), 32'h1);
      chk("fp_data1", 0, 32'(yd[0]), 32'h1111);
      chk("fp_sel1", 0, 32'(ys[0]), 32'h1);
      chk("fp_ready1", 0, 32'(yr[0]), 32'h2);
      step();
      xv[0] = 4'b1000;
      @(negedge clk);
      chk("fp_data1b", 0, 32'(yd[0]), 32'h1111);
      chk("fp_ready3", 0, 32'(yr[0]), 32'h8);
      step();
      @(negedge clk);
      chk("fp_data3", 0, 32'(yd[0]), 32'h3333);
      chk("fp_sel3", 0, 32'(ys[0]), 32'h3);
      step();
      xv[0] = 4'b0000;

      // Round robin, all valid, one beat per cycle with wrap.
      xd[1] = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
      xv[1] = 4'b1111;
      xr[1] = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         if (i == 6)
            xr[1] = 1'b0;
         @(negedge clk);
         chk("rr_valid", 1, 32'(yv[1]), 32'h1);
         chk("rr_data", 1, 32'(yd[1]), 32'hA000 + 32'(i % 4));
         chk("rr_sel", 1, 32'(ys[1]), 32'(i % 4));
      end

      // Stall holds A002 and accepts nothing.
      repeat (3) begin
         step();
         @(negedge clk);
         chk("st_data", 1, 32'(yd[1]), 32'hA002);
         chk("st_ready", 1, 32'(yr[1]), 32'h0);
         chk("st_valid", 1, 32'(yv[1]), 32'h1);
      end
      step();
      xr[1] = 1'b1;
      @(negedge clk);
      chk("st_next", 1, 32'(yr[1]), 32'h8);
      step();
      xv[1] = 4'b0100;
      @(negedge clk);
      chk("st_data3", 1, 32'(yd[1]), 32'hA003);
      chk("st_sel3", 1, 32'(ys[1]), 32'h3);
      chk("wr_ready", 1, 32'(yr[1]), 32'h4);

      // Only ch2 valid: search from 3 wraps round to 2.
      step();
      @(negedge clk);
      chk("wr_sel", 1, 32'(ys[1]), 32'h2);
      chk("wr_ready2", 1, 32'(yr[1]), 32'h4);
      step();
      xv[1] = 4'b1100;
      @(negedge clk);
      chk("wr_sel2", 1, 32'(ys[1]), 32'h2);
      chk("wr_ptr3", 1, 32'(yr[1]), 32'h8);

      // Reset during a stall drops o_valid at once.
      step();
      xv[1] = 4'b0001;
      xr[1] = 1'b0;
      @(negedge clk);
      chk("rs_sel", 1, 32'(ys[1]), 32'h3);
      chk("rs_valid", 1, 32'(yv[1]), 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("rs_async_v", 1, 32'(yv[1]), 32'h0);
      chk("rs_async_d", 1, 32'(yd[1]), 32'h0);
      step();
      reset = 1'b0;
      xv[1] = 4'b1111;
      xr[1] = 1'b1;
      @(negedge clk);
      chk("rs_restart", 1, 32'(yr[1]), 32'h1);
      step();
      @(negedge clk);
      chk("rs_sel0", 1, 32'(ys[1]), 32'h0);
      chk("rs_data0", 1, 32'(yd[1]), 32'hA000);
      step();
      xv[1] = 4'b0000;

      // 2:1 mux with random valid/ready.
      run_c = 1'b1;
      repeat (10000) begin
         step();
         c_valid  = 2'($urandom_range(3));
         c_data   = 2'($urandom_range(3));
         c_iready = 1'($urandom_range(1));
      end
      step();
      c_valid  = 2'b00;
      c_iready = 1'b1;
      repeat (3) step();
      @(negedge clk);
      #1;
      run_c = 1'b0;
      chk("c_drain", 2, 32'(sbq.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
